// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-slot TDM demultiplexer.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_t;

    localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Two-bit slot position counter for the TDM demultiplexer.
// Priority: clear, then load_one, then advance (wraps modulo NUM_SLOTS).
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  advance,
    input  logic  load_one,
    input  logic  clear,
    output slot_t slot,
    output logic  last_slot
);

    slot_t r_slot;

    // NOTE: sequential state is always written with <= so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else if (clear) begin
            r_slot <= '0;
        end else if (load_one) begin
            r_slot <= slot_t'(1);
        end else if (advance) begin
            r_slot <= r_slot + slot_t'(1);
        end
    end

    assign slot      = r_slot;
    assign last_slot = (r_slot == LAST_SLOT);

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer with frame-sync tracking.
// Define TDM_DEMUX_ERRCNT_EN to add the saturating err_cnt output.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         frame_sync,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]   err_cnt
`endif
);

    state_t       r_state;
    logic [W-1:0] r_shadow [0:NUM_SLOTS-2];
    logic [W-1:0] r_y0, r_y1, r_y2, r_y3;
    logic         r_frame_valid;
    logic         r_locked;
    logic         r_sync_err;

    slot_t        w_slot;
    logic         w_last_slot;
    logic         w_sync;
    logic         w_data_beat;
    logic         w_misalign;
    logic         w_clear;

    // A marker always restarts the frame; an unmarked beat only counts once locked.
    assign w_sync      = din_valid & frame_sync;
    assign w_data_beat = din_valid & ~frame_sync & (r_state == LOCKED);
    assign w_misalign  = w_sync & (r_state == LOCKED) & (w_slot != '0);
    assign w_clear     = din_valid & ~frame_sync & (r_state == HUNT);

    tdm_slot_counter u_slot_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (w_data_beat),
        .load_one  (w_sync),
        .clear     (w_clear),
        .slot      (w_slot),
        .last_slot (w_last_slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_y0          <= '0;
            r_y1          <= '0;
            r_y2          <= '0;
            r_y3          <= '0;
            r_frame_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
            // NOTE: the shadow array is only three flops wide, so it is reset
            // like ordinary registers rather than treated as a RAM.
            for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= w_misalign;
            r_locked      <= (r_state == LOCKED) | w_sync;
            if (w_sync) begin
                r_shadow[0] <= din;
                r_state     <= LOCKED;
            end else if (w_data_beat) begin
                if (!w_last_slot) begin
                    r_shadow[w_slot] <= din;
                end else begin
                    r_y0          <= r_shadow[0];
                    r_y1          <= r_shadow[1];
                    r_y2          <= r_shadow[2];
                    r_y3          <= din;
                    r_frame_valid <= 1'b1;
                end
            end
        end
    end

    assign y0          = r_y0;
    assign y1          = r_y1;
    assign y2          = r_y2;
    assign y3          = r_y3;
    assign frame_valid = r_frame_valid;
    assign locked      = r_locked;
    assign sync_err    = r_sync_err;

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_misalign && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed table, corner sequences and
// randomized beats against a frame-list reference model.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [7:0] y0, y1, y2, y3;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    logic [0:0] b_din;
    logic       b_valid;
    logic       b_sync;
    logic [0:0] b_y0, b_y1, b_y2, b_y3;
    logic       b_fv;
    logic       b_locked;
    logic       b_err;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] b_err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdm_demux4 #(.W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
`ifdef TDM_DEMUX_ERRCNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    tdm_demux4 #(.W(1)) dut_w1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (b_din),
        .din_valid   (b_valid),
        .frame_sync  (b_sync),
        .y0          (b_y0),
        .y1          (b_y1),
        .y2          (b_y2),
        .y3          (b_y3),
        .frame_valid (b_fv),
        .locked      (b_locked),
        .sync_err    (b_err)
`ifdef TDM_DEMUX_ERRCNT_EN
        ,
        .err_cnt     (b_err_cnt)
`endif
    );

    // Reference model: a locked flag, the list of samples of the frame being
    // assembled, the last delivered frame and the error tally.
    bit         m_locked;
    logic [7:0] m_part[$];
    logic [7:0] m_y[4];
    bit         m_fv;
    bit         m_err;
    int         m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_locked = 0;
        m_part.delete();
        for (int i = 0; i < 4; i++) m_y[i] = '0;
        m_fv  = 0;
        m_err = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_step(input bit v, input bit s, input logic [7:0] d);
        m_fv  = 0;
        m_err = 0;
        if (!v) return;
        if (s) begin
            if (m_locked && m_part.size() != 0) begin
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
            end
            m_part.delete();
            m_part.push_back(d);
            m_locked = 1;
        end else if (m_locked) begin
            m_part.push_back(d);
            if (m_part.size() == 4) begin
                for (int i = 0; i < 4; i++) m_y[i] = m_part[i];
                m_fv = 1;
                m_part.delete();
            end
        end
    endfunction

    task automatic compare_model(input string tag);
        check({tag, ".y0"}, 32'(y0), 32'(m_y[0]));
        check({tag, ".y1"}, 32'(y1), 32'(m_y[1]));
        check({tag, ".y2"}, 32'(y2), 32'(m_y[2]));
        check({tag, ".y3"}, 32'(y3), 32'(m_y[3]));
        check({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
        check({tag, ".locked"}, 32'(locked), 32'(m_locked));
        check({tag, ".sync_err"}, 32'(sync_err), 32'(m_err));
`ifdef TDM_DEMUX_ERRCNT_EN
        check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
`endif
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are read there too.
    task automatic step(input bit v, input bit s, input logic [7:0] d, input string tag);
        din        = d;
        din_valid  = v;
        frame_sync = s;
        @(posedge clk);
        #1;
        model_step(v, s, d);
        compare_model(tag);
    endtask

    typedef struct {
        bit          v;
        bit          s;
        logic [7:0]  d;
        bit          fv;
        bit          err;
        bit          lk;
        logic [31:0] y;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        b_din      = '0;
        b_valid    = 1'b0;
        b_sync     = 1'b0;
        model_reset();

        tbl.push_back('{1, 0, 8'hAA, 0, 0, 0, 32'h0});
        tbl.push_back('{1, 0, 8'hBB, 0, 0, 0, 32'h0});
        tbl.push_back('{1, 1, 8'h11, 0, 0, 1, 32'h0});
        tbl.push_back('{1, 0, 8'h22, 0, 0, 1, 32'h0});
        tbl.push_back('{1, 0, 8'h33, 0, 0, 1, 32'h0});
        tbl.push_back('{1, 0, 8'h44, 1, 0, 1, 32'h11223344});
        tbl.push_back('{0, 0, 8'hEE, 0, 0, 1, 32'h11223344});
        tbl.push_back('{1, 1, 8'h01, 0, 0, 1, 32'h11223344});
        tbl.push_back('{1, 0, 8'h02, 0, 0, 1, 32'h11223344});
        tbl.push_back('{1, 1, 8'h05, 0, 1, 1, 32'h11223344});
        tbl.push_back('{1, 0, 8'h06, 0, 0, 1, 32'h11223344});
        tbl.push_back('{1, 0, 8'h07, 0, 0, 1, 32'h11223344});
        tbl.push_back('{1, 0, 8'h08, 1, 0, 1, 32'h05060708});
        tbl.push_back('{1, 0, 8'h09, 0, 0, 1, 32'h05060708});
        tbl.push_back('{1, 0, 8'h0A, 0, 0, 1, 32'h05060708});
        tbl.push_back('{1, 0, 8'h0B, 0, 0, 1, 32'h05060708});
        tbl.push_back('{1, 0, 8'h0C, 1, 0, 1, 32'h090A0B0C});
        tbl.push_back('{1, 1, 8'h0D, 0, 0, 1, 32'h090A0B0C});
        tbl.push_back('{1, 0, 8'h0E, 0, 0, 1, 32'h090A0B0C});
        tbl.push_back('{1, 0, 8'h0F, 0, 0, 1, 32'h090A0B0C});
        tbl.push_back('{1, 1, 8'h10, 0, 1, 1, 32'h090A0B0C});
        tbl.push_back('{1, 0, 8'h11, 0, 0, 1, 32'h090A0B0C});
        tbl.push_back('{1, 0, 8'h12, 0, 0, 1, 32'h090A0B0C});
        tbl.push_back('{1, 0, 8'h13, 1, 0, 1, 32'h10111213});

        repeat (2) @(posedge clk);
        #1;
        check("reset.y", {y0, y1, y2, y3}, 32'h0);
        check("reset.flags", {29'd0, frame_valid, locked, sync_err}, 32'h0);
        rst_n = 1'b1;

        // W=1: stream 0,1,1,0 with the marker on the first beat.
        b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_sync = (i == 0);
            b_din  = (i == 1 || i == 2) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
        end
        b_valid = 1'b0;
        b_sync  = 1'b0;
        check("w1.y", {28'd0, b_y0, b_y1, b_y2, b_y3}, 32'h6);
        check("w1.fv_pulse", 32'(b_fv), 32'd1);
        check("w1.locked", 32'(b_locked), 32'd1);
        @(posedge clk);
        #1;
        check("w1.fv_clear", 32'(b_fv), 32'd0);
        check("w1.y_hold", {28'd0, b_y0, b_y1, b_y2, b_y3}, 32'h6);

        // Directed table on the W=8 instance (still in HUNT).
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].d, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.y", i), {y0, y1, y2, y3}, tbl[i].y);
            check($sformatf("tbl%0d.fv", i), 32'(frame_valid), 32'(tbl[i].fv));
            check($sformatf("tbl%0d.err", i), 32'(sync_err), 32'(tbl[i].err));
            check($sformatf("tbl%0d.lk", i), 32'(locked), 32'(tbl[i].lk));
        end
`ifdef TDM_DEMUX_ERRCNT_EN
        check("tbl.err_cnt", 32'(err_cnt), 32'd2);
`endif

        // Frame stretched by three idle cycles between slots 1 and 2.
        step(1, 1, 8'h11, "idle.s0");
        step(1, 0, 8'h22, "idle.s1");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'hFF, "idle.gap");
            check("idle.gap_fv", 32'(frame_valid), 32'd0);
        end
        step(1, 0, 8'h33, "idle.s2");
        check("idle.s2_fv", 32'(frame_valid), 32'd0);
        step(1, 0, 8'h44, "idle.s3");
        check("idle.fv", 32'(frame_valid), 32'd1);
        check("idle.y", {y0, y1, y2, y3}, 32'h11223344);

        // Asynchronous reset after slot 2 of a frame.
        step(1, 1, 8'hA1, "rst.s0");
        step(1, 0, 8'hA2, "rst.s1");
        step(1, 0, 8'hA3, "rst.s2");
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst.y", {y0, y1, y2, y3}, 32'h0);
        check("rst.flags", {29'd0, frame_valid, locked, sync_err}, 32'h0);
`ifdef TDM_DEMUX_ERRCNT_EN
        check("rst.err_cnt", 32'(err_cnt), 32'd0);
`endif
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 8'(8'hC0 + i), "rst.nosync");
            check("rst.nosync_fv", 32'(frame_valid), 32'd0);
        end

        // Randomized beats against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 6) == 0),
                 8'($urandom), "rand");
        end

`ifdef TDM_DEMUX_ERRCNT_EN
        // 300 misaligned markers saturate the error counter.
        step(1, 1, 8'h00, "sat.first");
        for (int i = 0; i < 300; i++) begin
            step(1, 0, 8'h01, "sat.data");
            step(1, 1, 8'h02, "sat.mis");
        end
        check("sat.err_cnt", 32'(err_cnt), 32'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive end of the 4:1 selector path. A serial sample stream, one slot per valid beat, is captured into four channel registers, delineated by a frame-sync marker on slot 0. Completed frames are presented in parallel on y0..y3 with a one-cycle frame strobe. The block sits downstream of the 4:1 mux-based serialiser and tracks frame alignment, reporting loss of sync.

## Interface
Parameters:
- W, 1, sample width in bits (1..32)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- din  input  W  serial sample for the current slot
- din_valid  input  1  din and frame_sync qualify this cycle
- frame_sync  input  1  current valid sample is slot 0; ignored when din_valid=0
- y0, y1, y2, y3  output  W each  last complete frame, slots 0..3
- frame_valid  output  1  one-cycle pulse when y0..y3 update
- locked  output  1  high while in LOCKED state
- sync_err  output  1  one-cycle pulse on misaligned frame_sync
- err_cnt  output  8  saturating sync-error count (only with TDM_DEMUX_ERRCNT_EN)

## Operation
- States: HUNT (reset state), LOCKED.
- HUNT: valid beats with frame_sync=0 are discarded. A valid beat with frame_sync=1 stores din into shadow slot 0, sets slot counter to 1, and moves to LOCKED.
- LOCKED, valid beat, frame_sync=0: store din into shadow[slot], slot increments mod 4.
- On slot 3 capture: y0..y3 load shadow[0..2] and din together, frame_valid pulses, slot wraps to 0.
- LOCKED, valid beat, frame_sync=1 at slot 0: normal frame start. sync_err stays 0.
- LOCKED, valid beat, frame_sync=1 at slot 1..3: sync_err pulses. The partial frame is discarded, with no frame_valid and y unchanged. din is stored as slot 0, the slot counter is set to 1, and the block stays LOCKED.
- LOCKED, valid beat with frame_sync=0 at slot 0: accepted as slot 0. Sync is checked only at the marker, not required on every frame.
- din_valid=0: no state, slot or shadow change. Frames may be stretched by idle cycles.
- Outputs y0..y3 hold between frames. The shadow registers are internal only.

## Timing
- All outputs registered. A slot-3 sample accepted at edge N appears on y0..y3, with frame_valid=1, immediately after edge N, and frame_valid clears after edge N+1 unless another frame completes.
- Minimum frame is 4 consecutive valid cycles, so frame_valid can pulse at most every 4th cycle.
- sync_err asserts after the edge that accepts the misaligned beat, for one cycle.
- Reset values: y0..y3=0, frame_valid=0, sync_err=0, locked=0, err_cnt=0, state HUNT, slot=0, shadow registers=0.
- rst_n is asserted asynchronously. Deassertion is synchronised upstream by the clock/reset block. Reset mid-frame drops the partial frame, and the block re-enters HUNT.

## Configuration
- TDM_DEMUX_ERRCNT_EN defined:
  - err_cnt port present.
  - It increments on each sync_err pulse and saturates at 255.
  - It is cleared only by rst_n.
- TDM_DEMUX_ERRCNT_EN undefined: err_cnt port and counter logic are absent. All other behaviour is identical.

## Structure
- Package tdm_pkg contains:
  - NUM_SLOTS=4
  - slot_t (2-bit)
  - the state enum {HUNT, LOCKED}
- Sub-module tdm_slot_counter holds the 2-bit slot counter.
  - Inputs: advance, load_one, clear.
  - Outputs: slot and the last_slot flag.
- The top level holds the FSM, the shadow and output registers, and the optional error counter.

## Test plan
- Reset then W=1. Valid stream 0,1,1,0 with frame_sync on the first beat -> after the 4th edge y0=0, y1=1, y2=1, y3=0, frame_valid pulses for 1 cycle, locked=1.
- W=8, in HUNT. Send 0xAA,0xBB without sync, then sync frame 0x11,0x22,0x33,0x44 -> first two discarded, y0..y3=0x11,0x22,0x33,0x44, exactly one frame_valid.
- Locked. Send 0x01,0x02, then frame_sync with 0x05,0x06,0x07,0x08 -> sync_err pulses once, no frame_valid for the partial frame, then y0..y3=0x05..0x08. With TDM_DEMUX_ERRCNT_EN, err_cnt=1.
- Frame 0x11..0x44 with din_valid low for 3 cycles between slots 1 and 2 -> same output values, frame_valid only after the slot-3 edge.
- rst_n low after slot 2 of a frame -> all outputs 0 immediately, locked=0. The next frame without a sync beat produces no frame_valid.
- With TDM_DEMUX_ERRCNT_EN, 300 misaligned syncs -> err_cnt=255.
